// File: rtl/timing_sequencer_pkg.sv
// Shared types and widths for the control-unit sequence counter and timing generator.
package timing_sequencer_pkg;

  localparam int SC_W = 4;
  localparam int T_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // Out-of-range load values saturate at the last timing step.
  function automatic logic [SC_W-1:0] clampLoad(input logic [SC_W-1:0] val,
                                                input logic [SC_W-1:0] maxSc);
    return (val > maxSc) ? maxSc : val;
  endfunction

endpackage

// File: rtl/timing_sequencer_incr.sv
// 4-bit half-adder incrementer: sum = a + 1, carry out when a is all ones.
module BinaryIncrementer (
  input  logic [3:0] a_i,
  output logic [3:0] sum_o,
  output logic       carry_o
);

  // Each bit flips when every lower bit is one (the half-adder carry chain, flattened).
  assign sum_o   = a_i ^ {&a_i[2:0], &a_i[1:0], a_i[0], 1'b1};
  assign carry_o = &a_i;

endmodule

// File: rtl/timing_sequencer.sv
// Sequence counter SC with one-hot timing decode, run/halt FSM and completed-cycle counter.
module timing_sequencer
  import timing_sequencer_pkg::*;
#(
  parameter int MAX_T = 15,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic             resume,
  input  logic             stop,
  input  logic             clr,
  input  logic             load,
  input  logic [SC_W-1:0]  load_val,
  output logic [SC_W-1:0]  sc,
  output logic [T_W-1:0]   t,
  output logic             busy,
  output logic             halted,
  output logic             cycle_done,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam logic [SC_W-1:0] MaxSc = SC_W'(MAX_T);

  state_e           state_q, state_d;
  logic [SC_W-1:0]  sc_q, sc_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SC_W-1:0]  incSum;
  logic             carry_unused;
  logic [SC_W-1:0]  loadClamped;

  BinaryIncrementer uIncr (
    .a_i     (sc_q),
    .sum_o   (incSum),
    .carry_o (carry_unused)
  );

  assign loadClamped = clampLoad(load_val, MaxSc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sc_q    <= '0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  // A completed cycle is SC reaching 0 from a nonzero value while running, by wrap or clr.
  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    done_d  = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
      sc_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sc_d = '0;
          if (start) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (clr) begin
            sc_d   = '0;
            done_d = (sc_q != '0);
          end else if (load) begin
            sc_d = loadClamped;
          end else if (sc_q == MaxSc) begin
            sc_d   = '0;
            done_d = 1'b1;
          end else begin
            sc_d = incSum;
          end
          if (halt) state_d = ST_HALT;
        end
        ST_HALT: begin
          if (load) sc_d = loadClamped;
          if (resume) state_d = ST_RUN;
        end
        default: begin
          state_d = ST_IDLE;
          sc_d    = '0;
        end
      endcase
    end
    cnt_d = done_d ? cnt_q + CNT_W'(1) : cnt_q;
  end

  always_comb begin
    t       = '0;
    t[sc_q] = 1'b1;
  end

  assign sc         = sc_q;
  assign busy       = (state_q == ST_RUN);
  assign halted     = (state_q == ST_HALT);
  assign cycle_done = done_q;
  assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_timing_sequencer.sv
// Randomised and directed checks of timing_sequencer (MAX_T = 15 and MAX_T = 7) against an integer model.
module tb_timing_sequencer;

  localparam int NDUT = 2;

  logic       clk;
  logic       rst_n;
  logic       start, halt, resume, stop, clr, load;
  logic [3:0] load_val;

  logic [3:0]  scO     [NDUT];
  logic [15:0] tO      [NDUT];
  logic        busyO   [NDUT];
  logic        haltedO [NDUT];
  logic        doneO   [NDUT];
  logic [7:0]  cntO    [NDUT];

  int nCompared;
  int nMismatched;

  // Model state: 0 = idle, 1 = run, 2 = halt.
  int maxT  [NDUT];
  int mSt   [NDUT];
  int mSc   [NDUT];
  int mDone [NDUT];
  int mCnt  [NDUT];

  timing_sequencer #(.MAX_T(15), .CNT_W(8)) dutA (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .resume(resume),
    .stop(stop), .clr(clr), .load(load), .load_val(load_val),
    .sc(scO[0]), .t(tO[0]), .busy(busyO[0]), .halted(haltedO[0]),
    .cycle_done(doneO[0]), .cycle_cnt(cntO[0])
  );

  timing_sequencer #(.MAX_T(7), .CNT_W(8)) dutB (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .resume(resume),
    .stop(stop), .clr(clr), .load(load), .load_val(load_val),
    .sc(scO[1]), .t(tO[1]), .busy(busyO[1]), .halted(haltedO[1]),
    .cycle_done(doneO[1]), .cycle_cnt(cntO[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void modelReset();
    for (int i = 0; i < NDUT; i++) begin
      mSt[i] = 0; mSc[i] = 0; mDone[i] = 0; mCnt[i] = 0;
    end
  endfunction

  function automatic void modelStep(int i);
    int mt, lv, st, s, d;
    mt = maxT[i];
    lv = (int'(load_val) > mt) ? mt : int'(load_val);
    st = mSt[i]; s = mSc[i]; d = 0;
    if (stop) begin
      st = 0; s = 0;
    end else if (mSt[i] == 0) begin
      s = 0;
      if (start) st = 1;
    end else if (mSt[i] == 1) begin
      if (clr) begin d = (s != 0) ? 1 : 0; s = 0; end
      else if (load) s = lv;
      else if (s == mt) begin s = 0; d = 1; end
      else s = s + 1;
      if (halt) st = 2;
    end else begin
      if (load) s = lv;
      if (resume) st = 1;
    end
    mSt[i] = st; mSc[i] = s; mDone[i] = d;
    if (d != 0) mCnt[i] = (mCnt[i] + 1) % 256;
  endfunction

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < NDUT; i++) modelStep(i);
    #1;
  endtask

  task automatic clearInputs();
    start = 0; halt = 0; resume = 0; stop = 0; clr = 0; load = 0; load_val = 4'd0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clearInputs();
    @(negedge clk);
    rst_n = 1'b0;
    modelReset();
    #1;
    for (int i = 0; i < NDUT; i++) begin
      nCompared++;
      if (scO[i] !== 4'd0) begin nMismatched++; $display("[TB] FAIL reset_sc dut%0d got %0d want 0", i, scO[i]); end
      nCompared++;
      if (tO[i] !== 16'h0001) begin nMismatched++; $display("[TB] FAIL reset_t dut%0d got %h want 0001", i, tO[i]); end
      nCompared++;
      if (busyO[i] !== 1'b0 || haltedO[i] !== 1'b0) begin
        nMismatched++; $display("[TB] FAIL reset_flags dut%0d got busy=%b halted=%b want 0/0", i, busyO[i], haltedO[i]);
      end
      nCompared++;
      if (doneO[i] !== 1'b0 || cntO[i] !== 8'd0) begin
        nMismatched++; $display("[TB] FAIL reset_cnt dut%0d got done=%b cnt=%0d want 0/0", i, doneO[i], cntO[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_run_wrap();
    int doneSeenA;
    doneSeenA = 0;
    doReset();
    start = 1; tick(); start = 0;
    nCompared++;
    if (busyO[0] !== 1'b1 || scO[0] !== 4'd0) begin
      nMismatched++; $display("[TB] FAIL start_latency got busy=%b sc=%0d want 1/0", busyO[0], scO[0]);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      if (doneO[0] === 1'b1) doneSeenA++;
      for (int i = 0; i < NDUT; i++) begin
        nCompared++;
        if (scO[i] !== 4'(mSc[i]) || tO[i] !== (16'd1 << mSc[i]) || doneO[i] !== 1'(mDone[i])) begin
          nMismatched++;
          $display("[TB] FAIL run_step dut%0d k=%0d got sc=%0d t=%h done=%b want sc=%0d t=%h done=%0d",
                   i, k, scO[i], tO[i], doneO[i], mSc[i], 16'd1 << mSc[i], mDone[i]);
        end
      end
    end
    nCompared++;
    if (scO[0] !== 4'd4 || cntO[0] !== 8'd1 || doneSeenA != 1) begin
      nMismatched++; $display("[TB] FAIL run20_A got sc=%0d cnt=%0d pulses=%0d want 4/1/1", scO[0], cntO[0], doneSeenA);
    end
    nCompared++;
    if (cntO[1] !== 8'd2) begin nMismatched++; $display("[TB] FAIL run20_B_cnt got %0d want 2", cntO[1]); end
  endtask

  task automatic test_clr_wrap();
    doReset();
    start = 1; tick(); start = 0;
    for (int k = 0; k < 20 && mSc[1] != 3; k++) tick();
    clr = 1; tick(); clr = 0;
    nCompared++;
    if (scO[1] !== 4'd0 || doneO[1] !== 1'b1 || cntO[1] !== 8'd1) begin
      nMismatched++; $display("[TB] FAIL clr_at3 got sc=%0d done=%b cnt=%0d want 0/1/1", scO[1], doneO[1], cntO[1]);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      nCompared++;
      if (scO[1] !== 4'(mSc[1]) || doneO[1] !== 1'(mDone[1])) begin
        nMismatched++; $display("[TB] FAIL clr_run got sc=%0d done=%b want %0d/%0d", scO[1], doneO[1], mSc[1], mDone[1]);
      end
    end
    nCompared++;
    if (scO[1] !== 4'd0 || doneO[1] !== 1'b1 || cntO[1] !== 8'd2) begin
      nMismatched++; $display("[TB] FAIL wrap7 got sc=%0d done=%b cnt=%0d want 0/1/2", scO[1], doneO[1], cntO[1]);
    end
    clr = 1; tick(); clr = 0;
    nCompared++;
    if (doneO[1] !== 1'b0 || cntO[1] !== 8'd2) begin
      nMismatched++; $display("[TB] FAIL clr_at0 got done=%b cnt=%0d want 0/2", doneO[1], cntO[1]);
    end
  endtask

  task automatic test_load_clr();
    doReset();
    start = 1; tick(); start = 0;
    tick(); tick(); tick();
    load = 1; load_val = 4'd9; clr = 1; tick(); clr = 0;
    nCompared++;
    if (scO[0] !== 4'd0 || scO[1] !== 4'd0) begin
      nMismatched++; $display("[TB] FAIL load_clr got A=%0d B=%0d want 0/0", scO[0], scO[1]);
    end
    load_val = 4'd12; tick(); load = 0;
    nCompared++;
    if (scO[0] !== 4'd12 || doneO[0] !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL load12 got sc=%0d done=%b want 12/0", scO[0], doneO[0]);
    end
    nCompared++;
    if (scO[1] !== 4'd7) begin nMismatched++; $display("[TB] FAIL load_clamp got %0d want 7", scO[1]); end
    load = 1; load_val = 4'd0; tick(); load = 0;
    nCompared++;
    if (scO[0] !== 4'd0 || doneO[0] !== 1'b0 || cntO[0] !== 4'(mCnt[0])) begin
      nMismatched++; $display("[TB] FAIL load0 got sc=%0d done=%b cnt=%0d want 0/0/%0d", scO[0], doneO[0], cntO[0], mCnt[0]);
    end
  endtask

  task automatic test_halt();
    doReset();
    start = 1; tick(); start = 0;
    for (int k = 0; k < 20 && mSc[0] != 5; k++) tick();
    halt = 1; tick(); halt = 0;
    nCompared++;
    if (scO[0] !== 4'd6 || haltedO[0] !== 1'b1 || busyO[0] !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL halt got sc=%0d halted=%b busy=%b want 6/1/0", scO[0], haltedO[0], busyO[0]);
    end
    clr = 1;
    for (int k = 0; k < 10; k++) begin
      tick();
      nCompared++;
      if (scO[0] !== 4'd6) begin nMismatched++; $display("[TB] FAIL halt_hold k=%0d got %0d want 6", k, scO[0]); end
    end
    clr = 0;
    load = 1; load_val = 4'd2; tick(); load = 0;
    nCompared++;
    if (scO[0] !== 4'd2) begin nMismatched++; $display("[TB] FAIL halt_load got %0d want 2", scO[0]); end
    halt = 1; resume = 1; tick(); halt = 0; resume = 0;
    nCompared++;
    if (busyO[0] !== 1'b1 || scO[0] !== 4'(mSc[0])) begin
      nMismatched++; $display("[TB] FAIL resume got busy=%b sc=%0d want 1/%0d", busyO[0], scO[0], mSc[0]);
    end
    tick();
    nCompared++;
    if (scO[0] !== 4'd3) begin nMismatched++; $display("[TB] FAIL resume_step got %0d want 3", scO[0]); end
    halt = 1; resume = 1; tick(); halt = 0; resume = 0;
    nCompared++;
    if (haltedO[0] !== 1'b1) begin nMismatched++; $display("[TB] FAIL run_halt_wins got halted=%b want 1", haltedO[0]); end
  endtask

  task automatic test_start_stop();
    doReset();
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    nCompared++;
    if (busyO[0] !== 1'b0 || scO[0] !== 4'd0) begin
      nMismatched++; $display("[TB] FAIL start_stop got busy=%b sc=%0d want 0/0", busyO[0], scO[0]);
    end
    start = 1; tick(); start = 0;
    tick(); tick(); tick();
    halt = 1; tick(); halt = 0;
    stop = 1; tick(); stop = 0;
    nCompared++;
    if (scO[0] !== 4'd0 || haltedO[0] !== 1'b0 || busyO[0] !== 1'b0 || doneO[0] !== 1'b0) begin
      nMismatched++; $display("[TB] FAIL halt_stop got sc=%0d halted=%b busy=%b done=%b want 0/0/0/0",
                              scO[0], haltedO[0], busyO[0], doneO[0]);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      start    = ($urandom_range(0, 99) < 20);
      halt     = ($urandom_range(0, 99) < 8);
      resume   = ($urandom_range(0, 99) < 25);
      stop     = ($urandom_range(0, 99) < 3);
      clr      = ($urandom_range(0, 99) < 8);
      load     = ($urandom_range(0, 99) < 12);
      load_val = 4'($urandom_range(0, 15));
      tick();
      for (int i = 0; i < NDUT; i++) begin
        nCompared++;
        if (scO[i] !== 4'(mSc[i]) || tO[i] !== (16'd1 << mSc[i]) || busyO[i] !== (mSt[i] == 1) ||
            haltedO[i] !== (mSt[i] == 2) || doneO[i] !== 1'(mDone[i]) || cntO[i] !== 8'(mCnt[i])) begin
          nMismatched++;
          $display("[TB] FAIL random dut%0d k=%0d got sc=%0d t=%h busy=%b halted=%b done=%b cnt=%0d want sc=%0d st=%0d done=%0d cnt=%0d",
                   i, k, scO[i], tO[i], busyO[i], haltedO[i], doneO[i], cntO[i], mSc[i], mSt[i], mDone[i], mCnt[i]);
        end
      end
    end
    clearInputs();
  endtask

  task automatic test_async_reset();
    stop = 1; tick(); stop = 0;
    start = 1; tick(); start = 0;
    load = 1; load_val = 4'd10; tick(); load = 0;
    nCompared++;
    if (scO[0] !== 4'd10) begin nMismatched++; $display("[TB] FAIL pre_reset_sc got %0d want 10", scO[0]); end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    nCompared++;
    if (scO[0] !== 4'd0 || tO[0] !== 16'h0001 || busyO[0] !== 1'b0 || cntO[0] !== 8'd0) begin
      nMismatched++; $display("[TB] FAIL async_reset got sc=%0d t=%h busy=%b cnt=%0d want 0/0001/0/0",
                              scO[0], tO[0], busyO[0], cntO[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1; tick(); start = 0;
    tick();
    nCompared++;
    if (busyO[0] !== 1'b1 || scO[0] !== 4'd1) begin
      nMismatched++; $display("[TB] FAIL post_reset_run got busy=%b sc=%0d want 1/1", busyO[0], scO[0]);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    maxT[0] = 15;
    maxT[1] = 7;
    rst_n = 1'b0;
    clearInputs();
    modelReset();
    test_reset();
    test_run_wrap();
    test_clr_wrap();
    test_load_clr();
    test_halt();
    test_start_stop();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/timing_sequencer.md
# timing_sequencer

Sequence counter and timing generator for the basic-computer control unit. Holds the 4-bit sequence count SC and advances it through the half-adder incrementer on every enabled clock. Decodes SC into one-hot timing signals T0..T15 for the control-logic decoder. A small run/halt state machine and a completed-cycle counter sit around it.

## Interface
- MAX_T, 15: last timing step; SC wraps to 0 after this value (legal 1..15).
- CNT_W, 8: width of the completed-cycle counter.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  IDLE -> RUN request.
- halt  in  1  RUN -> HALT request.
- resume  in  1  HALT -> RUN request.
- stop  in  1  any state -> IDLE; SC cleared.
- clr  in  1  synchronous SC <- 0 (end of instruction); effective in RUN only.
- load  in  1  synchronous SC <- load_val; effective in RUN and HALT.
- load_val  in  4  value for load; values above MAX_T are clamped to MAX_T.
- sc  out  4  current sequence count.
- t  out  16  one-hot decode of sc; t[i] = (sc == i).
- busy  out  1  high in RUN.
- halted  out  1  high in HALT.
- cycle_done  out  1  one-cycle pulse when SC returns to 0 from RUN (wrap or clr).
- cycle_cnt  out  CNT_W  number of cycle_done pulses, wraps modulo 2^CNT_W.

## Operation
- States: IDLE, RUN, HALT. Reset state is IDLE.
- IDLE: SC held at 0. start -> RUN. halt, resume, clr and load are ignored.
- RUN: every cycle SC updates by priority: stop > clr > load > increment.
  - Increment: next SC = incrementer sum, except that SC == MAX_T gives 0.
  - halt (without stop) -> HALT. The SC update for that cycle still happens.
- HALT: SC frozen. load is applied. resume -> RUN. clr is ignored.
- Any state: stop -> IDLE and SC <- 0. stop wins over start, halt and resume in the same cycle.
- Simultaneous halt and resume in RUN: halt wins. In HALT, resume wins.
- Incrementer carry-out is not an output. Wrap is decided by the MAX_T compare, so MAX_T = 15 and a carry-out give the same result.
- cycle_done asserts when, in RUN, SC becomes 0 by wrap or by clr.
  - It does not assert for load of 0, for stop, or when clr is applied while SC is already 0.
- cycle_cnt increments on each cycle_done and is cleared only by reset.

## Timing
- Reset values: sc = 0, t = 16'h0001, busy = 0, halted = 0, cycle_done = 0, cycle_cnt = 0, state IDLE.
- sc, busy, halted, cycle_done and cycle_cnt are registered. t is combinational from sc, so it has zero added latency.
- start sampled high at edge k: busy = 1 after edge k. The first increment occurs at edge k+1, so sc = 1 after k+1.
- cycle_done is high during the cycle in which sc reads 0 after the wrap or clr edge. cycle_cnt updates on the same edge.
- Reset asserted mid-operation clears all state asynchronously, regardless of clk. Operation resumes from IDLE after rst_n deasserts.
- Throughput: one SC step per clock in RUN, with no bubbles.

## Structure
- Shared package: state encoding (IDLE, RUN, HALT as a 2-bit typedef), SC width constant 4, timing-vector width 16.
- Sub-module: one instance of the existing 4-bit half-adder BinaryIncrementer.
  - Its A input is SC and its sum is the increment value.
  - Its carry-out is left unconnected.
- Decoder, wrap compare, FSM and cycle counter are coded inline in timing_sequencer.

## Test plan
- Reset then start, run 20 cycles with MAX_T = 15 -> sc 1..15, 0, 1..4. t one-hot tracks sc. One cycle_done, at the 15 -> 0 step; cycle_cnt = 1.
- MAX_T = 7, run; pulse clr at sc = 3 -> sc goes 3 -> 0 with cycle_done. Then sc goes 7 -> 0 with cycle_done; cycle_cnt = 2.
- In RUN, load load_val = 9 together with clr -> sc = 0 (clr wins). Next, load 12 alone -> sc = 12, no cycle_done.
- In RUN at sc = 5, halt -> sc = 6 and halted = 1. Sc stays 6 for 10 cycles. load 2 -> sc = 2. resume -> sc = 3 on the next edge.
- start and stop in the same cycle from IDLE -> stays IDLE, sc = 0, busy = 0. stop in HALT -> IDLE, sc = 0.
- Drive rst_n low between clock edges while sc = 10 -> sc = 0, t = 16'h0001 and busy = 0 immediately, without waiting for clk. cycle_cnt = 0.
